// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode-class and condition-code
// constants, and the default reset vector.
package cpu_pkg;

  // Fetch FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Opcode classes (upper nibble / extended nibble of op field)
  localparam logic [3:0] JCOND_UP  = 4'b0100;
  localparam logic [3:0] JCOND_EXT = 4'b1100;
  localparam logic [3:0] BCOND     = 4'b1100;

  // Condition codes
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;

  localparam logic [15:0] CPU_RESET_VEC = 16'h0000;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] imm;
  } instr_fields_t;

endpackage

// File: rtl/instr_field_split.sv
// Splits an instruction word into the 8-bit op field and the sign-extended
// 8-bit immediate. Purely combinational; shared with the decoder.
module instr_field_split
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output logic [7:0]  op_out,
  output logic [15:0] imm_out
);

  instr_fields_t f;

  // Field extraction
  always_comb begin
    f.op  = {instr[15:12], instr[7:4]};
    f.imm = {{8{instr[7]}}, instr[7:0]};
  end

  assign op_out  = f.op;
  assign imm_out = f.imm;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch stage. Fetches at pc_out over a
// req/ack handshake, holds the instruction until the core loads next_pc.
// Optional macro FETCH_TIMEOUT_EN: abort a fetch that waits TIMEOUT cycles,
// redirect to TRAP_VEC and pulse fault.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = CPU_RESET_VEC,
  parameter logic [7:0]  TIMEOUT   = 8'd32,
  parameter logic [15:0] TRAP_VEC  = 16'h00F0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] pc_out,
  output logic [15:0] instr_out,
  output logic [7:0]  op_out,
  output logic [15:0] imm_out,
  output logic        instr_valid,
  input  logic [15:0] next_pc,
  input  logic        pc_load,
  input  logic        stall,
  output logic        fault
);

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        mem_rd_q, mem_rd_d;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
`else
  wire unused_cfg = ^{TIMEOUT, TRAP_VEC};
`endif

  // Next-state logic for the fetch FSM
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    mem_rd_d = mem_rd_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    fault_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d  = ST_FETCH;
        mem_rd_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        cnt_d    = 8'd0;
`endif
      end
      ST_FETCH: begin
        if (!mem_rd_q) begin
          // re-issue after an aborted fetch; any ack here belongs to nobody
          mem_rd_d = 1'b1;
        end else if (mem_ack) begin
          instr_d  = mem_rdata;
          valid_d  = 1'b1;
          mem_rd_d = 1'b0;
          state_d  = ST_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == TIMEOUT - 8'd1) begin
          mem_rd_d = 1'b0;
          pc_d     = TRAP_VEC;
          fault_d  = 1'b1;
          cnt_d    = 8'd0;
        end else begin
          cnt_d    = cnt_q + 8'd1;
        end
`endif
      end
      ST_HOLD: begin
        // stall beats pc_load; the core must re-assert pc_load afterwards
        if (pc_load && !stall) begin
          pc_d     = next_pc;
          valid_d  = 1'b0;
          mem_rd_d = 1'b1;
          state_d  = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops mem_rd immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_VEC;
      instr_q  <= 16'h0000;
      valid_q  <= 1'b0;
      mem_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      mem_rd_q <= mem_rd_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Timeout counter and fault pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  instr_field_split u_split (
    .instr   (instr_q),
    .op_out  (op_out),
    .imm_out (imm_out)
  );

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = pc_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: expected instructions are queued when the ack is
// driven and compared when instr_valid comes up.
module tb_pc_fetch_unit;

  logic        clk, rst_n;
  logic        mem_rd, mem_ack, instr_valid, pc_load, stall, fault;
  logic [15:0] mem_addr, mem_rdata, pc_out, instr_out, imm_out, next_pc;
  logic [7:0]  op_out;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [7:0]  op;
    logic [15:0] imm;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  pc_fetch_unit #(.RESET_VEC(16'h0000), .TIMEOUT(8'd4), .TRAP_VEC(16'h00F0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_out(pc_out),
    .instr_out(instr_out), .op_out(op_out), .imm_out(imm_out),
    .instr_valid(instr_valid), .next_pc(next_pc), .pc_load(pc_load),
    .stall(stall), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expect FETCH at pc for dly wait cycles, then ack with data
  task automatic do_fetch(input logic [15:0] pc, input int dly, input logic [15:0] data);
    exp_t e;
    for (int i = 0; i < dly; i++) begin
      chk("wait_rd", 32'(mem_rd), 32'd1);
      chk("wait_addr", 32'(mem_addr), 32'(pc));
      chk("wait_valid", 32'(instr_valid), 32'd0);
      step();
    end
    chk("fetch_rd", 32'(mem_rd), 32'd1);
    chk("fetch_addr", 32'(mem_addr), 32'(pc));
    mem_ack   = 1'b1;
    mem_rdata = data;
    sb.push_back('{pc: pc, instr: data, op: {data[15:12], data[7:4]},
                   imm: {{8{data[7]}}, data[7:0]}});
    step();
    mem_ack   = 1'b0;
    mem_rdata = 16'hDEAD;
    chk("valid", 32'(instr_valid), 32'd1);
    chk("hold_rd", 32'(mem_rd), 32'd0);
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc", 32'(pc_out), 32'(e.pc));
      chk("instr", 32'(instr_out), 32'(e.instr));
      chk("op", 32'(op_out), 32'(e.op));
      chk("imm", 32'(imm_out), 32'(e.imm));
    end
  endtask

  // From HOLD: pc_load with stall for nstall cycles, then release
  task automatic do_load(input logic [15:0] npc, input int nstall);
    logic [15:0] pc0;
    pc0     = pc_out;
    next_pc = npc;
    pc_load = 1'b1;
    stall   = 1'b1;
    for (int i = 0; i < nstall; i++) begin
      step();
      chk("stall_pc", 32'(pc_out), 32'(pc0));
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_rd", 32'(mem_rd), 32'd0);
    end
    stall = 1'b0;
    step();
    pc_load = 1'b0;
    next_pc = 16'h5555;
    chk("load_pc", 32'(pc_out), 32'(npc));
    chk("load_rd", 32'(mem_rd), 32'd1);
    chk("load_addr", 32'(mem_addr), 32'(npc));
    chk("load_valid", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    next_pc = 16'h0000; pc_load = 1'b0; stall = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc", 32'(pc_out), 32'h0000);
    chk("rst_addr", 32'(mem_addr), 32'h0000);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'h0000);
    chk("rst_op", 32'(op_out), 32'h00);
    chk("rst_imm", 32'(imm_out), 32'h0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    rst_n = 1'b1;
    chk("idle_rd", 32'(mem_rd), 32'd0);
    step();
    do_fetch(16'h0000, 0, 16'hC1FE);

    do_load(16'h0010, 0);
    do_fetch(16'h0010, 0, 16'h1234);

    do_load(16'h0040, 3);
    do_fetch(16'h0040, 5, 16'h5A80);

    // acks while holding must be ignored
    held = instr_out;
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step(); step();
    mem_ack = 1'b0;
    chk("hold_ack_instr", 32'(instr_out), 32'(held));
    chk("hold_ack_valid", 32'(instr_valid), 32'd1);
    chk("hold_ack_rd", 32'(mem_rd), 32'd0);
    chk("no_dup", 32'(sb.size()), 32'd0);

    // PC wrap is carried verbatim
    do_load(16'hFFFF, 0);
    do_fetch(16'hFFFF, 1, 16'h4C07);
    do_load(16'h0000, 1);
    do_fetch(16'h0000, 0, 16'h0070);

    // async reset mid-fetch
    do_load(16'h0100, 0);
    step();
    chk("mid_rd", 32'(mem_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd", 32'(mem_rd), 32'd0);
    chk("arst_pc", 32'(pc_out), 32'h0000);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_idle_rd", 32'(mem_rd), 32'd0);
    step();
    do_fetch(16'h0000, 2, 16'h8123);

`ifdef FETCH_TIMEOUT_EN
    do_load(16'h0200, 0);
    for (int i = 0; i < 4; i++) begin
      chk("to_rd", 32'(mem_rd), 32'd1);
      chk("to_nofault", 32'(fault), 32'd0);
      if (i < 3) step();
    end
    step();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_pc", 32'(pc_out), 32'h00F0);
    chk("to_rd_drop", 32'(mem_rd), 32'd0);
    step();
    chk("to_fault_clr", 32'(fault), 32'd0);
    do_fetch(16'h00F0, 0, 16'hC2FC);
    // ack on the terminal count wins over the timeout
    do_load(16'h0300, 0);
    do_fetch(16'h0300, 3, 16'h1111);
    chk("to_race_fault", 32'(fault), 32'd0);
`else
    chk("fault_tied", 32'(fault), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
